// File: rtl/core_pkg.sv
// Shared widths and ALU opcodes for the 8-bit, 8-register pipelined core.
// No logic, so no latency or backpressure of its own.
package core_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam logic ALU_ADD  = 1'b1;
    localparam logic ALU_MOV  = 1'b0;
endpackage

// File: rtl/fwd_unit.sv
// EX/WB -> EX bypass detect: flags source operands written by the instruction in EX/WB.
// Purely combinational, zero latency; has no flow control of its own.
module fwd_unit #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_reg_num_i,
    input  logic [REG_ADDR_W-1:0] rd_num1_i,
    input  logic [REG_ADDR_W-1:0] rd_num2_i,
    output logic                  fwd_a_o,
    output logic                  fwd_b_o
);
    // Register 0 is an ordinary register here, so no zero-register exclusion.
    assign fwd_a_o = wb_regwrite_i && (wb_reg_num_i == rd_num1_i);
    assign fwd_b_o = wb_regwrite_i && (wb_reg_num_i == rd_num2_i);
endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage (ADD/MOV with EX/WB forwarding) plus EX/WB register and retire counter.
// Latency 1 cycle; Stall holds the register and counter, Flush inserts a bubble and wins over Stall.
module ex_wb_stage #(
    parameter int DATA_W     = core_pkg::DATA_W,
    parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ID_EX_RegWrite,
    input  logic                  ID_EX_ALU_Ctrl,
    input  logic [DATA_W-1:0]     ID_EX_Data1,
    input  logic [DATA_W-1:0]     ID_EX_Data2,
    input  logic [REG_ADDR_W-1:0] ID_EX_Write_Reg_Num,
    input  logic [REG_ADDR_W-1:0] ID_EX_Read_Reg_Num1,
    input  logic [REG_ADDR_W-1:0] ID_EX_Read_Reg_Num2,
    output logic                  EX_WB_RegWrite,
    output logic [DATA_W-1:0]     EX_WB_Write_Data,
    output logic [REG_ADDR_W-1:0] EX_WB_Write_Reg_Num,
    output logic                  EX_WB_Carry,
    output logic                  EX_WB_Zero,
    output logic                  Fwd_A,
    output logic                  Fwd_B,
    output logic [CNT_W-1:0]      Retire_Count
);
    import core_pkg::*;

    logic                  regwrite_q, regwrite_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [REG_ADDR_W-1:0] reg_num_q, reg_num_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_W-1:0]     op_a, op_b, alu_res;
    logic [DATA_W:0]       sum;
    logic                  alu_carry;

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .wb_regwrite_i (regwrite_q),
        .wb_reg_num_i  (reg_num_q),
        .rd_num1_i     (ID_EX_Read_Reg_Num1),
        .rd_num2_i     (ID_EX_Read_Reg_Num2),
        .fwd_a_o       (Fwd_A),
        .fwd_b_o       (Fwd_B)
    );

    assign op_a = Fwd_A ? data_q : ID_EX_Data1;
    assign op_b = Fwd_B ? data_q : ID_EX_Data2;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        alu_res   = op_b;
        alu_carry = 1'b0;
        if (ID_EX_ALU_Ctrl == ALU_ADD) begin
            alu_res   = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
        end
    end

    always_comb begin
        regwrite_d = regwrite_q;
        data_d     = data_q;
        reg_num_d  = reg_num_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        if (Flush) begin
            regwrite_d = 1'b0;
            data_d     = '0;
            reg_num_d  = '0;
            carry_d    = 1'b0;
            zero_d     = 1'b0;
        end else if (!Stall) begin
            regwrite_d = ID_EX_RegWrite;
            data_d     = alu_res;
            reg_num_d  = ID_EX_Write_Reg_Num;
            carry_d    = alu_carry;
            zero_d     = (alu_res == '0);
            cnt_d      = cnt_q + CNT_W'(ID_EX_RegWrite);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regwrite_q <= 1'b0;
            data_q     <= '0;
            reg_num_q  <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            data_q     <= data_d;
            reg_num_q  <= reg_num_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign EX_WB_RegWrite      = regwrite_q;
    assign EX_WB_Write_Data    = data_q;
    assign EX_WB_Write_Reg_Num = reg_num_q;
    assign EX_WB_Carry         = carry_q;
    assign EX_WB_Zero          = zero_q;
    assign Retire_Count        = cnt_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed cases with literal expectations plus random traffic
// checked every cycle against a behavioural model of the stage.
module tb_ex_wb_stage;
    localparam int CW = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Stall = 1'b0;
    logic       Flush = 1'b0;
    logic       ID_EX_RegWrite = 1'b0;
    logic       ID_EX_ALU_Ctrl = 1'b0;
    logic [7:0] ID_EX_Data1 = '0;
    logic [7:0] ID_EX_Data2 = '0;
    logic [2:0] ID_EX_Write_Reg_Num = '0;
    logic [2:0] ID_EX_Read_Reg_Num1 = '0;
    logic [2:0] ID_EX_Read_Reg_Num2 = '0;
    logic       EX_WB_RegWrite;
    logic [7:0] EX_WB_Write_Data;
    logic [2:0] EX_WB_Write_Reg_Num;
    logic       EX_WB_Carry;
    logic       EX_WB_Zero;
    logic       Fwd_A;
    logic       Fwd_B;
    logic [CW-1:0] Retire_Count;

    int n_checks = 0;
    int n_errors = 0;

    ex_wb_stage #(.DATA_W(8), .REG_ADDR_W(3), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_ALU_Ctrl(ID_EX_ALU_Ctrl),
        .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2),
        .ID_EX_Write_Reg_Num(ID_EX_Write_Reg_Num),
        .ID_EX_Read_Reg_Num1(ID_EX_Read_Reg_Num1),
        .ID_EX_Read_Reg_Num2(ID_EX_Read_Reg_Num2),
        .EX_WB_RegWrite(EX_WB_RegWrite), .EX_WB_Write_Data(EX_WB_Write_Data),
        .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num), .EX_WB_Carry(EX_WB_Carry),
        .EX_WB_Zero(EX_WB_Zero), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B),
        .Retire_Count(Retire_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the last captured instruction's effect, plus a plain retire tally.
    int m_rw = 0, m_data = 0, m_reg = 0, m_c = 0, m_z = 0, m_cnt = 0;

    always @(negedge Clk) begin
        int fa, fb, a, b, res, c;
        if (Reset) begin
            m_rw = 0; m_data = 0; m_reg = 0; m_c = 0; m_z = 0; m_cnt = 0;
            chk("rst_regwrite", EX_WB_RegWrite, 0);
            chk("rst_data", EX_WB_Write_Data, 0);
            chk("rst_count", Retire_Count, 0);
        end else begin
            fa = (m_rw == 1 && m_reg == ID_EX_Read_Reg_Num1) ? 1 : 0;
            fb = (m_rw == 1 && m_reg == ID_EX_Read_Reg_Num2) ? 1 : 0;
            chk("m_fwd_a", Fwd_A, fa);
            chk("m_fwd_b", Fwd_B, fb);
            chk("m_regwrite", EX_WB_RegWrite, m_rw);
            chk("m_data", EX_WB_Write_Data, m_data);
            chk("m_reg", EX_WB_Write_Reg_Num, m_reg);
            chk("m_carry", EX_WB_Carry, m_c);
            chk("m_zero", EX_WB_Zero, m_z);
            chk("m_count", Retire_Count, m_cnt);
            a = fa ? m_data : int'(ID_EX_Data1);
            b = fb ? m_data : int'(ID_EX_Data2);
            if (ID_EX_ALU_Ctrl) begin
                res = (a + b) % 256;
                c = (a + b) / 256;
            end else begin
                res = b;
                c = 0;
            end
            if (Flush) begin
                m_rw = 0; m_data = 0; m_reg = 0; m_c = 0; m_z = 0;
            end else if (!Stall) begin
                m_rw = int'(ID_EX_RegWrite);
                m_data = res;
                m_reg = int'(ID_EX_Write_Reg_Num);
                m_c = c;
                m_z = (res == 0) ? 1 : 0;
                if (ID_EX_RegWrite) m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic alu, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [2:0] wr, input logic [2:0] r1, input logic [2:0] r2);
        ID_EX_RegWrite = rw; ID_EX_ALU_Ctrl = alu;
        ID_EX_Data1 = d1; ID_EX_Data2 = d2;
        ID_EX_Write_Reg_Num = wr; ID_EX_Read_Reg_Num1 = r1; ID_EX_Read_Reg_Num2 = r2;
    endtask

    initial begin
        tick();
        chk("reset_data", EX_WB_Write_Data, 0);
        chk("reset_count", Retire_Count, 0);
        Reset = 1'b0;

        drive(1, 1, 8'h05, 8'h07, 3'd3, 3'd1, 3'd2);
        tick();
        chk("add_data", EX_WB_Write_Data, 8'h0C);
        chk("add_carry", EX_WB_Carry, 0);
        chk("add_zero", EX_WB_Zero, 0);
        chk("add_reg", EX_WB_Write_Reg_Num, 3);
        chk("add_count", Retire_Count, 1);

        drive(1, 1, 8'h00, 8'h00, 3'd4, 3'd3, 3'd3);
        #1;
        chk("fwd_a_hit", Fwd_A, 1);
        chk("fwd_b_hit", Fwd_B, 1);
        tick();
        chk("fwd_data", EX_WB_Write_Data, 8'h18);
        chk("fwd_count", Retire_Count, 2);

        Stall = 1'b1;
        drive(1, 1, 8'h33, 8'h44, 3'd6, 3'd4, 3'd0);
        tick();
        tick();
        chk("stall_data", EX_WB_Write_Data, 8'h18);
        chk("stall_reg", EX_WB_Write_Reg_Num, 4);
        chk("stall_count", Retire_Count, 2);
        chk("stall_fwd_a", Fwd_A, 1);

        Flush = 1'b1;
        tick();
        chk("flush_regwrite", EX_WB_RegWrite, 0);
        chk("flush_data", EX_WB_Write_Data, 0);
        chk("flush_reg", EX_WB_Write_Reg_Num, 0);
        chk("flush_count", Retire_Count, 2);
        Flush = 1'b0; Stall = 1'b0;

        drive(0, 1, 8'h05, 8'h07, 3'd3, 3'd1, 3'd2);
        tick();
        chk("norw_count", Retire_Count, 2);
        drive(1, 1, 8'h00, 8'h00, 3'd4, 3'd3, 3'd3);
        #1;
        chk("nofwd_a", Fwd_A, 0);
        chk("nofwd_b", Fwd_B, 0);
        tick();
        chk("nofwd_data", EX_WB_Write_Data, 0);

        drive(1, 1, 8'hFF, 8'h01, 3'd5, 3'd1, 3'd2);
        tick();
        chk("wrap_data", EX_WB_Write_Data, 0);
        chk("wrap_carry", EX_WB_Carry, 1);
        chk("wrap_zero", EX_WB_Zero, 1);
        drive(1, 0, 8'hFF, 8'h00, 3'd6, 3'd1, 3'd2);
        tick();
        chk("mov_data", EX_WB_Write_Data, 0);
        chk("mov_carry", EX_WB_Carry, 0);
        chk("mov_zero", EX_WB_Zero, 1);

        drive(1, 1, 8'h01, 8'h02, 3'd7, 3'd0, 3'd0);
        tick();
        chk("pre_rst_data", EX_WB_Write_Data, 8'h03);
        Reset = 1'b1;
        #1;
        chk("async_rst_data", EX_WB_Write_Data, 0);
        chk("async_rst_regwrite", EX_WB_RegWrite, 0);
        chk("async_rst_reg", EX_WB_Write_Reg_Num, 0);
        chk("async_rst_count", Retire_Count, 0);
        chk("async_rst_fwd", Fwd_A, 0);
        tick();
        Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 8'(i), 8'h10, 3'(i), 3'd0, 3'd0);
            tick();
            drive(0, 0, 8'h00, 8'h20, 3'd1, 3'd0, 3'd0);
            tick();
        end
        chk("cnt_15", Retire_Count, 15);
        drive(1, 1, 8'h01, 8'h01, 3'd2, 3'd5, 3'd5);
        tick();
        chk("cnt_wrap", Retire_Count, 0);

        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 199) == 0);
            Stall = ($urandom_range(0, 4) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom));
            tick();
        end
        Reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
